// File: rtl/prefetch_buffer_if.sv
// Bundle of prefetch request, memory burst, lookup and invalidate signals between the
// requester/cache side (master) and the single-line prefetch buffer (slave).
interface prefetch_buffer_if;
    logic         pref_read_i;
    logic [31:0]  pref_addr_i;
    logic         pref_resp_o;
    logic         pmem_read_o;
    logic [31:0]  pmem_addr_o;
    logic [63:0]  pmem_rdata_i;
    logic         pmem_resp_i;
    logic         lookup_i;
    logic [31:0]  lookup_addr_i;
    logic         lookup_hit_o;
    logic [255:0] lookup_line_o;
    logic         inval_i;
    logic [31:0]  inval_addr_i;

    modport master (
        output pref_read_i, pref_addr_i, pmem_rdata_i, pmem_resp_i,
        output lookup_i, lookup_addr_i, inval_i, inval_addr_i,
        input  pref_resp_o, pmem_read_o, pmem_addr_o, lookup_hit_o, lookup_line_o
    );

    modport slave (
        input  pref_read_i, pref_addr_i, pmem_rdata_i, pmem_resp_i,
        input  lookup_i, lookup_addr_i, inval_i, inval_addr_i,
        output pref_resp_o, pmem_read_o, pmem_addr_o, lookup_hit_o, lookup_line_o
    );
endinterface

// File: rtl/prefetch_buffer.sv
// Single-line (256-bit, 4 x 64-bit beats) prefetch buffer with 4-phase request handshake,
// combinational lookup port and address-matched invalidation.
module prefetch_buffer (
    input  logic             clk_i,
    input  logic             rst_n_i,
    prefetch_buffer_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

    state_e         r_state, w_state_d;
    logic [255:0]   r_line, w_line_d;
    logic [26:0]    r_tag, w_tag_d;
    logic           r_valid, w_valid_d;
    logic [1:0]     r_cnt, w_cnt_d;
    logic           r_stale, w_stale_d;

    logic           w_pref_hit;
    logic           w_inval_hit;
    logic [7:0]     w_beat_lsb;
    logic           w_unused_offsets;

    assign w_pref_hit  = r_valid && (bus_io.pref_addr_i[31:5] == r_tag);
    assign w_inval_hit = bus_io.inval_i && (bus_io.inval_addr_i[31:5] == r_tag);
    assign w_beat_lsb  = {r_cnt, 6'b0};

    // Byte offsets inside the line never matter to this block.
    assign w_unused_offsets = ^{bus_io.pref_addr_i[4:0], bus_io.lookup_addr_i[4:0],
                                bus_io.inval_addr_i[4:0]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
            r_line  <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= 2'd0;
            r_stale <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_line  <= w_line_d;
            r_tag   <= w_tag_d;
            r_valid <= w_valid_d;
            r_cnt   <= w_cnt_d;
            r_stale <= w_stale_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_line_d  = r_line;
        w_tag_d   = r_tag;
        w_valid_d = r_valid;
        w_cnt_d   = r_cnt;
        w_stale_d = r_stale;

        case (r_state)
            StIdle: begin
                if (bus_io.pref_read_i) begin
                    if (w_pref_hit) begin
                        w_state_d = StDone;
                    end else begin
                        w_tag_d   = bus_io.pref_addr_i[31:5];
                        w_valid_d = 1'b0;
                        w_stale_d = 1'b0;
                        w_cnt_d   = 2'd0;
                        w_state_d = StBurst;
                    end
                end
            end
            StBurst: begin
                // An invalidate racing the fill only marks it stale; the burst still runs out.
                if (w_inval_hit) begin
                    w_stale_d = 1'b1;
                end
                if (bus_io.pmem_resp_i) begin
                    w_line_d[w_beat_lsb +: 64] = bus_io.pmem_rdata_i;
                    w_cnt_d                    = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_valid_d = ~(r_stale | w_inval_hit);
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!bus_io.pref_read_i) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_inval_hit && (r_state != StBurst)) begin
            w_valid_d = 1'b0;
        end
    end

    assign bus_io.pref_resp_o   = (r_state == StDone);
    assign bus_io.pmem_read_o   = (r_state == StBurst);
    assign bus_io.pmem_addr_o   = {r_tag, 5'b0};
    assign bus_io.lookup_hit_o  = bus_io.lookup_i && r_valid &&
                                  (bus_io.lookup_addr_i[31:5] == r_tag);
    assign bus_io.lookup_line_o = r_line;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench for prefetch_buffer: directed fills, lookup vector table, invalidate and
// reset corner cases, then random traffic against a line-level reference model.
module tb_prefetch_buffer;

    logic clk;
    logic rst_n;

    prefetch_buffer_if bus ();

    prefetch_buffer dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: just what the buffer should hold.
    logic         m_valid;
    logic [26:0]  m_tag;
    logic [255:0] m_line;

    logic [63:0]  beats [4];
    logic [31:0]  pool  [4];

    typedef struct {
        logic        lk;
        logic [31:0] addr;
        logic        exp_hit;
    } lk_vec_t;

    lk_vec_t tbl [7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_check(input logic [31:0] addr);
        bus.lookup_i      = 1'b1;
        bus.lookup_addr_i = addr;
        #1;
        chk1("lookup_hit", bus.lookup_hit_o, m_valid && (m_tag == addr[31:5]));
        chk("lookup_line", bus.lookup_line_o, m_line);
        bus.lookup_i = 1'b0;
    endtask

    // Full prefetch handshake; inval_beat outside 0..3 means no invalidate during the burst.
    task automatic prefetch(input logic [31:0] addr, input int gap, input int inval_beat,
                            input logic [31:0] inval_addr);
        logic         miss;
        logic [255:0] fill;
        fill = '0;
        miss = !(m_valid && (m_tag == addr[31:5]));
        bus.pref_read_i = 1'b1;
        bus.pref_addr_i = addr;
        step();
        if (miss) begin
            chk1("burst_read", bus.pmem_read_o, 1'b1);
            chk("burst_addr", 256'(bus.pmem_addr_o), 256'({addr[31:5], 5'b0}));
            chk1("burst_no_resp", bus.pref_resp_o, 1'b0);
            bus.lookup_i      = 1'b1;
            bus.lookup_addr_i = addr;
            #1;
            chk1("midburst_hit", bus.lookup_hit_o, 1'b0);
            bus.lookup_i = 1'b0;
            for (int k = 0; k < 4; k++) begin
                repeat (gap) step();
                bus.pmem_resp_i  = 1'b1;
                bus.pmem_rdata_i = beats[k];
                fill[64*k +: 64] = beats[k];
                if (k == inval_beat) begin
                    bus.inval_i      = 1'b1;
                    bus.inval_addr_i = inval_addr;
                end
                step();
                bus.pmem_resp_i = 1'b0;
                bus.inval_i     = 1'b0;
            end
            chk1("fill_resp", bus.pref_resp_o, 1'b1);
            chk1("fill_read_drop", bus.pmem_read_o, 1'b0);
            m_tag   = addr[31:5];
            m_line  = fill;
            m_valid = !(inval_beat >= 0 && inval_beat < 4 && inval_addr[31:5] == addr[31:5]);
        end else begin
            chk1("redundant_resp", bus.pref_resp_o, 1'b1);
            chk1("redundant_no_read", bus.pmem_read_o, 1'b0);
        end
        step();
        chk1("resp_held", bus.pref_resp_o, 1'b1);
        bus.pref_read_i = 1'b0;
        step();
        chk1("resp_drop", bus.pref_resp_o, 1'b0);
        chk1("idle_no_read", bus.pmem_read_o, 1'b0);
        lookup_check(addr);
    endtask

    task automatic inval_idle(input logic [31:0] addr);
        bus.inval_i      = 1'b1;
        bus.inval_addr_i = addr;
        step();
        bus.inval_i = 1'b0;
        if (addr[31:5] == m_tag) m_valid = 1'b0;
        lookup_check(addr);
    endtask

    task automatic stray(input logic [63:0] data);
        bus.pmem_resp_i  = 1'b1;
        bus.pmem_rdata_i = data;
        step();
        bus.pmem_resp_i = 1'b0;
        chk("stray_line", bus.lookup_line_o, m_line);
        chk1("stray_no_read", bus.pmem_read_o, 1'b0);
    endtask

    initial begin
        pool[0] = 32'h0000_1000;
        pool[1] = 32'h0000_1040;
        pool[2] = 32'h8000_0020;
        pool[3] = 32'h0000_2000;

        tbl[0] = '{lk: 1'b1, addr: 32'h0000_1040, exp_hit: 1'b1};
        tbl[1] = '{lk: 1'b1, addr: 32'h0000_105C, exp_hit: 1'b1};
        tbl[2] = '{lk: 1'b1, addr: 32'h0000_1060, exp_hit: 1'b0};
        tbl[3] = '{lk: 1'b0, addr: 32'h0000_1040, exp_hit: 1'b0};
        tbl[4] = '{lk: 1'b1, addr: 32'h0000_103F, exp_hit: 1'b0};
        tbl[5] = '{lk: 1'b1, addr: 32'hFFFF_1040, exp_hit: 1'b0};
        tbl[6] = '{lk: 1'b1, addr: 32'h0000_1050, exp_hit: 1'b1};

        bus.pref_read_i   = 1'b0;
        bus.pref_addr_i   = '0;
        bus.pmem_rdata_i  = '0;
        bus.pmem_resp_i   = 1'b0;
        bus.lookup_i      = 1'b0;
        bus.lookup_addr_i = '0;
        bus.inval_i       = 1'b0;
        bus.inval_addr_i  = '0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_line  = '0;

        rst_n = 1'b0;
        #12;
        chk1("rst_resp", bus.pref_resp_o, 1'b0);
        chk1("rst_read", bus.pmem_read_o, 1'b0);
        chk("rst_addr", 256'(bus.pmem_addr_o), 256'(0));
        chk("rst_line", bus.lookup_line_o, 256'(0));
        step();
        rst_n = 1'b1;

        // Miss fill of 0x1044.
        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        prefetch(32'h0000_1044, 0, -1, 32'h0);
        chk("fill_line_const", bus.lookup_line_o,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        for (int i = 0; i < 7; i++) begin
            bus.lookup_i      = tbl[i].lk;
            bus.lookup_addr_i = tbl[i].addr;
            #1;
            chk1($sformatf("tbl_hit_%0d", i), bus.lookup_hit_o, tbl[i].exp_hit);
            chk($sformatf("tbl_line_%0d", i), bus.lookup_line_o, m_line);
        end
        bus.lookup_i = 1'b0;

        // Redundant prefetch of the same line: no memory traffic.
        prefetch(32'h0000_1048, 0, -1, 32'h0);

        // Invalidate in idle, then invalidate racing beat 2, then refetch.
        inval_idle(32'h0000_1050);
        beats[0] = 64'hA0A0_0000_0000_0001;
        beats[1] = 64'hA0A0_0000_0000_0002;
        beats[2] = 64'hA0A0_0000_0000_0003;
        beats[3] = 64'hA0A0_0000_0000_0004;
        prefetch(32'h0000_1040, 0, 2, 32'h0000_1050);
        prefetch(32'h0000_1040, 0, -1, 32'h0);

        // Invalidate coinciding with the final beat.
        beats[0] = 64'hB0B0_0000_0000_0011;
        prefetch(32'h0000_3000, 1, 3, 32'h0000_3010);

        // Non-matching invalidates have no effect.
        prefetch(32'h0000_1040, 0, 1, 32'h0000_5000);
        inval_idle(32'h0000_5000);

        // Stalled beats and stray responses in idle.
        beats[0] = 64'hC0C0_0000_0000_0021;
        beats[1] = 64'hC0C0_0000_0000_0022;
        beats[2] = 64'hC0C0_0000_0000_0023;
        beats[3] = 64'hC0C0_0000_0000_0024;
        prefetch(32'h0000_4400, 3, -1, 32'h0);
        stray(64'hDEAD_BEEF_DEAD_BEEF);

        // Reset after beat 1 abandons the burst; held request restarts cleanly.
        bus.pref_read_i = 1'b1;
        bus.pref_addr_i = 32'h0000_2000;
        step();
        chk1("rb_read", bus.pmem_read_o, 1'b1);
        for (int k = 0; k < 2; k++) begin
            bus.pmem_resp_i  = 1'b1;
            bus.pmem_rdata_i = 64'hEEEE_0000_0000_0000 | 64'(k);
            step();
        end
        bus.pmem_resp_i = 1'b0;
        #2;
        rst_n = 1'b0;
        bus.lookup_i      = 1'b1;
        bus.lookup_addr_i = 32'h0;
        #1;
        chk1("rb_resp", bus.pref_resp_o, 1'b0);
        chk1("rb_read_low", bus.pmem_read_o, 1'b0);
        chk("rb_addr", 256'(bus.pmem_addr_o), 256'(0));
        chk("rb_line", bus.lookup_line_o, 256'(0));
        chk1("rb_hit", bus.lookup_hit_o, 1'b0);
        bus.lookup_i = 1'b0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_line  = '0;
        step();
        rst_n = 1'b1;
        beats[0] = 64'hF000_0000_0000_0000;
        beats[1] = 64'hF000_0000_0000_0001;
        beats[2] = 64'hF000_0000_0000_0002;
        beats[3] = 64'hF000_0000_0000_0003;
        prefetch(32'h0000_2000, 0, -1, 32'h0);

        // Random traffic against the model.
        for (int it = 0; it < 40; it++) begin
            logic [31:0] addr;
            logic [31:0] iaddr;
            int          op;
            int          ib;
            addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            op   = int'($urandom_range(0, 3));
            if (op <= 1) begin
                for (int k = 0; k < 4; k++) beats[k] = {$urandom, $urandom};
                ib    = int'($urandom_range(0, 5));
                iaddr = ($urandom_range(0, 1) == 1) ? (addr ^ 32'h0000_0008)
                                                    : pool[$urandom_range(0, 3)];
                prefetch(addr, int'($urandom_range(0, 2)), ib, iaddr);
            end else if (op == 2) begin
                inval_idle(addr);
            end else begin
                stray({$urandom, $urandom});
                lookup_check(addr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
